// File: rtl/pc_unit.sv
// Program-counter unit: owns the fetch PC and picks the next PC from flush, branch, RAS pop, stall or increment.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
    parameter int unsigned          XLEN         = 64,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          INC          = 4,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush_en,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam logic [XLEN-1:0] IncVal = XLEN'(INC);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] ras_top;
    logic            valid_q;
    logic            misalign_q, misalign_d;
    logic            pop_hit;
    logic            target_misaligned;

    assign seq_pc            = pc_q + IncVal;
    assign target_misaligned = (INC == 2) ? branch_pc[0] : (|branch_pc[1:0]);

`ifdef PC_RAS_EN
    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [CntW-1:0] Depth = CntW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d, wr_idx;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ras_empty_q, ras_full_q;
    logic            ras_ok, push_go;

    // RAS moves only on a plain sequential cycle; any redirect or stall freezes it.
    assign ras_ok  = valid_q & ~stall & ~flush_en & ~branch_en;
    assign pop_hit = ras_ok & ras_pop & (cnt_q != '0);
    assign push_go = ras_ok & ras_push;
    assign ras_top = ras_q[ptr_q];
    assign wr_idx  = pop_hit ? ptr_q : ptr_q + 1'b1;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_go && !pop_hit) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q == Depth) ? cnt_q : cnt_q + 1'b1;
        end else if (pop_hit && !push_go) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ras_empty_q <= (cnt_d == '0);
            ras_full_q  <= (cnt_d == Depth);
        end
    end

    always_ff @(posedge clk) begin
        if (push_go) begin
            ras_q[wr_idx] <= seq_pc;
        end
    end

    assign ras_empty = ras_empty_q;
    assign ras_full  = ras_full_q;
`else
    logic unused_ras;
    assign unused_ras = &{1'b0, ras_push, ras_pop};
    assign pop_hit    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    // The first edge after reset only raises pc_valid, so RESET_VECTOR is fetched once.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (valid_q) begin
            if (flush_en) begin
                pc_d       = flush_pc;
                misalign_d = 1'b0;
            end else if (branch_en) begin
                pc_d = branch_pc;
                if (target_misaligned) begin
                    misalign_d = 1'b1;
                end
            end else if (pop_hit) begin
                pc_d = ras_top;
            end else if (!stall) begin
                pc_d = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = valid_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default parameters); RAS sequence runs when PC_RAS_EN is defined.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush_en;
    logic [63:0] flush_pc;
    logic        branch_en;
    logic [63:0] branch_pc;
    logic        ras_push;
    logic        ras_pop;
    logic [63:0] pc_out;
    logic        pc_valid;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush_en  (flush_en),
        .flush_pc  (flush_pc),
        .branch_en (branch_en),
        .branch_pc (branch_pc),
        .ras_push  (ras_push),
        .ras_pop   (ras_pop),
        .pc_out    (pc_out),
        .pc_valid  (pc_valid),
        .misalign  (misalign),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic branchTo(input logic [63:0] target);
        branch_en = 1'b1;
        branch_pc = target;
        step();
        branch_en = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        flush_en  = 1'b0;
        flush_pc  = '0;
        branch_en = 1'b1;
        branch_pc = 64'hDEAD_BEEF_DEAD_BEEF;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;

        #3;
        checkOutput("rst_pc", pc_out, 64'h0);
        checkOutput("rst_valid", {63'b0, pc_valid}, 64'h0);
        checkOutput("rst_misalign", {63'b0, misalign}, 64'h0);
        checkOutput("rst_empty", {63'b0, ras_empty}, 64'h1);
        checkOutput("rst_full", {63'b0, ras_full}, 64'h0);
        step();
        step();
        checkOutput("rst_hold_pc", pc_out, 64'h0);

        reset_n   = 1'b1;
        branch_en = 1'b0;
        step();
        checkOutput("first_valid", {63'b0, pc_valid}, 64'h1);
        checkOutput("first_pc", pc_out, 64'h0);
        step();
        checkOutput("seq_pc4", pc_out, 64'h4);
        step();
        checkOutput("seq_pc8", pc_out, 64'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_hold", pc_out, 64'h8);
        end
        branchTo(64'h8000_0000);
        checkOutput("branch_over_stall", pc_out, 64'h8000_0000);
        stall = 1'b0;

        flush_en = 1'b1;
        flush_pc = 64'h100;
        branchTo(64'h200);
        flush_en = 1'b0;
        checkOutput("flush_over_branch", pc_out, 64'h100);
        checkOutput("flush_misalign", {63'b0, misalign}, 64'h0);
        branchTo(64'h202);
        checkOutput("misalign_pc", pc_out, 64'h202);
        checkOutput("misalign_set", {63'b0, misalign}, 64'h1);
        step();
        checkOutput("misalign_seq_pc", pc_out, 64'h206);
        checkOutput("misalign_sticky", {63'b0, misalign}, 64'h1);
        stall    = 1'b1;
        flush_en = 1'b1;
        flush_pc = 64'h300;
        step();
        flush_en = 1'b0;
        stall    = 1'b0;
        checkOutput("flush_over_stall", pc_out, 64'h300);
        checkOutput("misalign_clear", {63'b0, misalign}, 64'h0);
        branchTo(64'h301);
        checkOutput("misalign_bit0", {63'b0, misalign}, 64'h1);
        flush_en = 1'b1;
        flush_pc = 64'h400;
        step();
        flush_en = 1'b0;
        checkOutput("misalign_clear2", {63'b0, misalign}, 64'h0);

        branchTo(64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        checkOutput("wrap_zero", pc_out, 64'h0);

`ifdef PC_RAS_EN
        for (int k = 1; k <= 5; k++) begin
            branchTo(64'(k * 16));
            ras_push = 1'b1;
            step();
            ras_push = 1'b0;
            checkOutput("push_seq_pc", pc_out, 64'(k * 16 + 4));
            if (k == 1) checkOutput("ras_not_empty", {63'b0, ras_empty}, 64'h0);
            if (k == 3) checkOutput("ras_not_full", {63'b0, ras_full}, 64'h0);
        end
        checkOutput("ras_full", {63'b0, ras_full}, 64'h1);
        ras_pop = 1'b1;
        step();
        checkOutput("pop1", pc_out, 64'h54);
        step();
        checkOutput("pop2", pc_out, 64'h44);
        step();
        checkOutput("pop3", pc_out, 64'h34);
        step();
        checkOutput("pop4", pc_out, 64'h24);
        checkOutput("ras_empty_after", {63'b0, ras_empty}, 64'h1);
        step();
        checkOutput("pop_empty_seq", pc_out, 64'h28);
        ras_pop = 1'b0;
`else
        ras_push = 1'b1;
        ras_pop  = 1'b1;
        step();
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        checkOutput("noras_pc", pc_out, 64'h4);
        checkOutput("noras_empty", {63'b0, ras_empty}, 64'h1);
        checkOutput("noras_full", {63'b0, ras_full}, 64'h0);
`endif

        branchTo(64'h2002);
        checkOutput("pre_rst_misalign", {63'b0, misalign}, 64'h1);
        branchTo(64'h2000);
        checkOutput("pre_rst_pc", pc_out, 64'h2000);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_pc", pc_out, 64'h0);
        checkOutput("async_valid", {63'b0, pc_valid}, 64'h0);
        checkOutput("async_misalign", {63'b0, misalign}, 64'h0);
        checkOutput("async_empty", {63'b0, ras_empty}, 64'h1);
        step();
        reset_n = 1'b1;
        step();
        checkOutput("rerun_valid", {63'b0, pc_valid}, 64'h1);
        checkOutput("rerun_pc", pc_out, 64'h0);
        step();
        checkOutput("rerun_pc4", pc_out, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
